zdos_trdemu_ctl: RTL and testbench



---
 rtl/zdos_trdemu_ctl_pkg.sv | 20 ++
 rtl/zdos_trdemu_ctl_if.sv | 38 +++
 rtl/zdos_trdemu_ctl_wdog.sv | 37 +++
 rtl/zdos_trdemu_ctl.sv | 103 ++++++++++
 tb/tb_zdos_trdemu_ctl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/zdos_trdemu_ctl_pkg.sv
// Shared types and helpers for the DOS/TR-DOS emulation control block.
package zdos_pkg;

  localparam int unsigned NUM_DRV_DFLT = 4;
  localparam int unsigned DRV_W_DFLT   = 2;
  localparam int unsigned CNT_W_DFLT   = 8;
  localparam int unsigned WDOG_W_DFLT  = 20;

  // 2'b11 is unused; the controller falls back to IDLE from it
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    EMU       = 2'b01,
    EXIT_PEND = 2'b10
  } state_e;

  function automatic logic [31:0] all_ones(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/zdos_trdemu_ctl_if.sv
// Glue-side signal bundle of the emulation controller (port decoder, NMI logic, mapper).
interface zdos_trdemu_ctl_if #(
  parameter int unsigned NUM_DRV = 4,
  parameter int unsigned DRV_W   = 2,
  parameter int unsigned CNT_W   = 8
);
  logic               dos_turn_on;
  logic               dos_turn_off;
  logic               cpm_n;
  logic               atm_pen2;
  logic               zpos;
  logic               m1_n;
  logic               in_nmi;
  logic               clr_nmi;
  logic               vg_rdwr_fclk;
  logic [NUM_DRV-1:0] fdd_mask;
  logic [DRV_W-1:0]   vg_a;
  logic               romnram;
  logic               wdog_en;
  logic               dos;
  logic               in_trdemu;
  logic               trdemu_wr_disable;
  logic [DRV_W-1:0]   trap_drv;
  logic [CNT_W-1:0]   trap_cnt;
  logic               wdog_fired;

  modport master (
    output dos_turn_on, dos_turn_off, cpm_n, atm_pen2, zpos, m1_n, in_nmi, clr_nmi,
           vg_rdwr_fclk, fdd_mask, vg_a, romnram, wdog_en,
    input  dos, in_trdemu, trdemu_wr_disable, trap_drv, trap_cnt, wdog_fired
  );

  modport slave (
    input  dos_turn_on, dos_turn_off, cpm_n, atm_pen2, zpos, m1_n, in_nmi, clr_nmi,
           vg_rdwr_fclk, fdd_mask, vg_a, romnram, wdog_en,
    output dos, in_trdemu, trdemu_wr_disable, trap_drv, trap_cnt, wdog_fired
  );
endinterface

// File: rtl/zdos_trdemu_ctl_wdog.sv
// Emulation watchdog: counts enabled cycles, pulses timeout on the step that reaches all-ones.
module zdos_wdog
  import zdos_pkg::*;
#(
  parameter int unsigned WDOG_W = WDOG_W_DFLT
) (
  input  logic fclk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic timeout_o
);

  localparam logic [WDOG_W-1:0] CNT_MAX = WDOG_W'(all_ones(WDOG_W));

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  assign timeout_o = inc_i & (cnt_q == (CNT_MAX - WDOG_W'(1)));

  always_ff @(posedge fclk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/zdos_trdemu_ctl.sv
// DOS ROM select and Beta-Disk trap controller with NMI-deferred exit, watchdog and trap statistics.
module zdos_trdemu_ctl
  import zdos_pkg::*;
#(
  parameter int unsigned NUM_DRV = NUM_DRV_DFLT,
  parameter int unsigned DRV_W   = DRV_W_DFLT,
  parameter int unsigned CNT_W   = CNT_W_DFLT,
  parameter int unsigned WDOG_W  = WDOG_W_DFLT
) (
  input logic               fclk,
  input logic               rst,
  zdos_trdemu_ctl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(all_ones(CNT_W));

  state_e           state_q, state_d;
  logic             dos_q, dos_d;
  logic             in_trdemu_q;
  logic             wr_dis_q, wr_dis_d;
  logic [DRV_W-1:0] trap_drv_q, trap_drv_d;
  logic [CNT_W-1:0] trap_cnt_q, trap_cnt_d;
  logic             wdog_fired_q, wdog_fired_d;
  logic             trap, entry, wdog_inc, wdog_to;

  // dos_q is the registered value, so a strobe only affects trapping from the next cycle
  assign trap     = bus.vg_rdwr_fclk & bus.fdd_mask[bus.vg_a] & dos_q & bus.romnram & ~bus.atm_pen2;
  assign entry    = (state_q == IDLE) & trap;
  assign wdog_inc = ((state_q == EMU) | (state_q == EXIT_PEND)) & bus.wdog_en;

  zdos_wdog #(.WDOG_W(WDOG_W)) u_wdog (
    .fclk      (fclk),
    .rst       (rst),
    .clr_i     (entry),
    .inc_i     (wdog_inc),
    .timeout_o (wdog_to)
  );

  always_comb begin
    state_d = state_q;
    if (wdog_to) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (trap) state_d = EMU;
        EMU:       if (bus.clr_nmi) state_d = bus.in_nmi ? EXIT_PEND : IDLE;
        EXIT_PEND: if (!bus.in_nmi) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    dos_d        = dos_q;
    wr_dis_d     = wr_dis_q;
    trap_drv_d   = trap_drv_q;
    trap_cnt_d   = trap_cnt_q;
    wdog_fired_d = wdog_fired_q;

    if (!bus.cpm_n)            dos_d = 1'b1;
    else if (bus.dos_turn_off) dos_d = 1'b0;
    else if (bus.dos_turn_on)  dos_d = 1'b1;

    if (bus.zpos && !bus.m1_n) wr_dis_d = 1'b0;
    else if (trap)             wr_dis_d = 1'b1;

    if (entry) begin
      trap_drv_d = bus.vg_a;
      if (trap_cnt_q != CNT_MAX) trap_cnt_d = trap_cnt_q + CNT_W'(1);
    end

    if (wdog_to)          wdog_fired_d = 1'b1;
    else if (bus.clr_nmi) wdog_fired_d = 1'b0;
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q      <= IDLE;
      dos_q        <= 1'b1;
      in_trdemu_q  <= 1'b0;
      wr_dis_q     <= 1'b0;
      trap_drv_q   <= '0;
      trap_cnt_q   <= '0;
      wdog_fired_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dos_q        <= dos_d;
      in_trdemu_q  <= (state_d != IDLE);
      wr_dis_q     <= wr_dis_d;
      trap_drv_q   <= trap_drv_d;
      trap_cnt_q   <= trap_cnt_d;
      wdog_fired_q <= wdog_fired_d;
    end
  end

  assign bus.dos               = dos_q;
  assign bus.in_trdemu         = in_trdemu_q;
  assign bus.trdemu_wr_disable = wr_dis_q;
  assign bus.trap_drv          = trap_drv_q;
  assign bus.trap_cnt          = trap_cnt_q;
  assign bus.wdog_fired        = wdog_fired_q;

endmodule

// File: tb/tb_zdos_trdemu_ctl.sv
// Bench for zdos_trdemu_ctl: directed scenarios plus random traffic against a behavioural model.
module tb_zdos_trdemu_ctl;

  localparam int NUM_DRV = 4;
  localparam int DRV_W   = 2;
  localparam int CNT_W   = 2;
  localparam int WDOG_W  = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;
  localparam int WD_LAST = (1 << WDOG_W) - 1;

  logic fclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 fclk = ~fclk;

  zdos_trdemu_ctl_if #(.NUM_DRV(NUM_DRV), .DRV_W(DRV_W), .CNT_W(CNT_W)) bus ();

  zdos_trdemu_ctl #(.NUM_DRV(NUM_DRV), .DRV_W(DRV_W), .CNT_W(CNT_W), .WDOG_W(WDOG_W)) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  // Behavioural model: mapped = emulation page in; waiting = exit requested during NMI
  bit m_dos, m_mapped, m_waiting, m_wrdis, m_fired;
  int m_drv, m_cnt, m_age;

  task automatic model_reset();
    m_dos = 1; m_mapped = 0; m_waiting = 0; m_wrdis = 0; m_fired = 0;
    m_drv = 0; m_cnt = 0; m_age = 0;
  endtask

  initial model_reset();

  always @(posedge fclk) begin
    bit trap, fire, enter;
    if (rst) begin
      model_reset();
    end else begin
      trap  = bus.vg_rdwr_fclk && bus.fdd_mask[bus.vg_a] && m_dos && bus.romnram && !bus.atm_pen2;
      fire  = m_mapped && bus.wdog_en && (m_age + 1 == WD_LAST);
      enter = !m_mapped && trap;
      if (enter) begin
        m_drv = int'(bus.vg_a);
        m_cnt = (m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT;
        m_age = 0;
      end else if (m_mapped && bus.wdog_en) begin
        m_age = m_age + 1;
      end
      if (fire) begin
        m_mapped = 0; m_waiting = 0;
      end else if (enter) begin
        m_mapped = 1;
      end else if (m_mapped && !m_waiting) begin
        if (bus.clr_nmi) begin
          m_waiting = bus.in_nmi;
          m_mapped  = bus.in_nmi;
        end
      end else if (m_waiting && !bus.in_nmi) begin
        m_mapped = 0; m_waiting = 0;
      end
      if (fire) m_fired = 1;
      else if (bus.clr_nmi) m_fired = 0;
      if (bus.zpos && !bus.m1_n) m_wrdis = 0;
      else if (trap) m_wrdis = 1;
      if (!bus.cpm_n) m_dos = 1;
      else if (bus.dos_turn_off) m_dos = 0;
      else if (bus.dos_turn_on) m_dos = 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge fclk) begin
    if (chk_en) begin
      chk("dos", int'(bus.dos), int'(m_dos));
      chk("in_trdemu", int'(bus.in_trdemu), int'(m_mapped));
      chk("wr_disable", int'(bus.trdemu_wr_disable), int'(m_wrdis));
      chk("trap_drv", int'(bus.trap_drv), m_drv);
      chk("trap_cnt", int'(bus.trap_cnt), m_cnt);
      chk("wdog_fired", int'(bus.wdog_fired), int'(m_fired));
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge fclk);
      #1;
    end
  endtask

  task automatic quiet();
    bus.dos_turn_on = 0; bus.dos_turn_off = 0; bus.clr_nmi = 0;
    bus.vg_rdwr_fclk = 0; bus.zpos = 0; bus.m1_n = 1;
  endtask

  task automatic pulse_trap();
    bus.vg_rdwr_fclk = 1; cyc(1); bus.vg_rdwr_fclk = 0;
  endtask

  task automatic pulse_clr(input bit nmi);
    bus.in_nmi = nmi; bus.clr_nmi = 1; cyc(1); bus.clr_nmi = 0;
  endtask

  initial begin
    quiet();
    bus.cpm_n = 1; bus.atm_pen2 = 0; bus.in_nmi = 0; bus.fdd_mask = 4'b0100;
    bus.vg_a = 2; bus.romnram = 1; bus.wdog_en = 0;
    rst = 1; cyc(2); rst = 0; chk_en = 1;
    @(negedge fclk);
    chk("rst_dos", int'(bus.dos), 1);
    chk("rst_in_trdemu", int'(bus.in_trdemu), 0);
    chk("rst_trap_cnt", int'(bus.trap_cnt), 0);

    bus.dos_turn_off = 1; bus.dos_turn_on = 1; cyc(1); quiet();
    @(negedge fclk); chk("dos_off_wins", int'(bus.dos), 0);
    bus.cpm_n = 0; bus.dos_turn_off = 1; cyc(1); quiet();
    @(negedge fclk); chk("cpm_forces_dos", int'(bus.dos), 1);
    bus.cpm_n = 1;

    bus.vg_a = 1; pulse_trap();
    @(negedge fclk); chk("masked_drive_no_trap", int'(bus.in_trdemu), 0);
    bus.vg_a = 2; pulse_trap();
    @(negedge fclk);
    chk("trap_in_trdemu", int'(bus.in_trdemu), 1);
    chk("trap_drv_lit", int'(bus.trap_drv), 2);
    chk("trap_cnt_lit", int'(bus.trap_cnt), 1);
    chk("trap_wrdis", int'(bus.trdemu_wr_disable), 1);

    pulse_clr(1);
    @(negedge fclk); chk("exit_pend_mapped", int'(bus.in_trdemu), 1);
    bus.in_nmi = 0; cyc(1);
    @(negedge fclk); chk("exit_after_nmi", int'(bus.in_trdemu), 0);

    pulse_trap();
    bus.in_nmi = 0; bus.clr_nmi = 1; bus.vg_rdwr_fclk = 1; cyc(1); quiet();
    @(negedge fclk);
    chk("clr_beats_trap", int'(bus.in_trdemu), 0);
    chk("clr_trap_cnt", int'(bus.trap_cnt), 2);
    for (int i = 0; i < 3; i++) begin
      pulse_trap(); pulse_clr(0);
    end
    @(negedge fclk); chk("cnt_saturates", int'(bus.trap_cnt), 3);

    bus.wdog_en = 1; pulse_trap(); cyc(14);
    @(negedge fclk); chk("wdog_not_yet", int'(bus.in_trdemu), 1);
    cyc(1);
    @(negedge fclk);
    chk("wdog_exit", int'(bus.in_trdemu), 0);
    chk("wdog_fired_lit", int'(bus.wdog_fired), 1);
    bus.wdog_en = 0; pulse_trap(); cyc(40);
    @(negedge fclk); chk("wdog_off_stays", int'(bus.in_trdemu), 1);
    pulse_clr(0);
    @(negedge fclk); chk("clr_clears_fired", int'(bus.wdog_fired), 0);

    bus.zpos = 1; bus.m1_n = 0; pulse_trap(); quiet();
    @(negedge fclk); chk("wrdis_clear_wins", int'(bus.trdemu_wr_disable), 0);
    pulse_clr(1);
    rst = 1; cyc(1); rst = 0;
    @(negedge fclk);
    chk("rst_mid_in_trdemu", int'(bus.in_trdemu), 0);
    chk("rst_mid_cnt", int'(bus.trap_cnt), 0);
    bus.in_nmi = 0;

    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 199) == 0);
      bus.cpm_n        = ($urandom_range(0, 19) != 0);
      bus.dos_turn_off = ($urandom_range(0, 29) == 0);
      bus.dos_turn_on  = ($urandom_range(0, 9) == 0);
      bus.atm_pen2     = ($urandom_range(0, 9) == 0);
      bus.zpos         = $urandom_range(0, 1);
      bus.m1_n         = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) bus.in_nmi = ~bus.in_nmi;
      bus.clr_nmi      = ($urandom_range(0, 24) == 0);
      bus.vg_rdwr_fclk = ($urandom_range(0, 4) == 0);
      bus.fdd_mask     = 4'($urandom);
      bus.vg_a         = 2'($urandom);
      bus.romnram      = ($urandom_range(0, 4) != 0);
      bus.wdog_en      = ($urandom_range(0, 4) != 0);
      cyc(1);
    end
    rst = 0; quiet();
    cyc(2);
    @(negedge fclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
